acc_argmax: RTL and testbench
=============================

# acc_argmax

Classification back end of the neuron datapath. It sits downstream of `acc`, after the `pipeline1` MAC. It captures one completed 22-bit neuron sum per strobe and tracks the running signed maximum across a frame of `N_CLASS` neurons. At the end of the frame it presents the winning class index and score to the host through a valid/ack handshake.

## Interface
Parameters:
- `DATA_W`, 22, width of `acc` output `dout`, two's-complement signed.
- `N_CLASS`, 10, neurons per frame (40 MAC beats / 4 beats per neuron).
- `IDX_W`, 4, width of class index; must satisfy 2^IDX_W >= N_CLASS.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `start`  in  1  one-cycle pulse; aborts any frame and begins a new one.
- `dout`  in  DATA_W  completed neuron sum from `acc`.
- `dout_valid`  in  1  `dout` holds a finished neuron sum; one sample per high cycle.
- `res_ack`  in  1  host consumed the result.
- `res_valid`  out  1  result registers hold a final frame result.
- `res_idx`  out  IDX_W  index (0-based, arrival order) of the maximum neuron.
- `res_score`  out  DATA_W  value of the maximum neuron.
- `busy`  out  1  frame in progress (state COLLECT).
- `overrun`  out  1  sticky; a sample arrived while in HOLD.

## Operation
- State machine with states IDLE, COLLECT and HOLD.
  - IDLE: the first `dout_valid` is sample 0; it loads max = `dout`, max_idx = 0, count = 1 and moves to COLLECT.
  - COLLECT: each `dout_valid` compares `dout` against max.
  - HOLD: `res_valid` = 1; outputs are frozen.
- Comparison rules:
  - Signed compare over the full DATA_W, with no truncation or saturation.
  - Replace max only if `dout` > max (strict), so ties keep the lowest index.
  - The sample index is the value of count before increment.
- Frame end: when the sample with index N_CLASS-1 is accepted, the FSM moves to HOLD. `res_idx`/`res_score` take the final max, including that last sample if it wins.
- HOLD exit: `res_ack` returns to IDLE and clears `res_valid`. `res_ack` outside HOLD is ignored.
- `dout_valid` in HOLD is dropped and sets `overrun` = 1. `overrun` clears only on `rst` or `start`.
- `start` in any state:
  - Clears count, `res_valid` and `overrun`, and goes to IDLE.
  - If `dout_valid` is high in the same cycle, that sample is taken as sample 0 of the new frame, so the FSM lands in COLLECT.
  - `start` wins over a simultaneous `res_ack`.
- count wraps are impossible because the frame ends at N_CLASS-1; count resets to 0 on entry to IDLE.
- `N_CLASS` = 1 is legal: the FSM goes from IDLE straight to HOLD on the first sample.

## Timing
- Reset values: `res_valid` 0, `res_idx` 0, `res_score` 0, `busy` 0, `overrun` 0, state IDLE, count 0.
- All outputs are registered, with no combinational path from input to output.
- Latency: `res_valid` rises on the clock edge that samples the last `dout_valid`, and is visible the cycle after it.
- Throughput: back-to-back `dout_valid` every cycle is supported. Minimum frame is N_CLASS cycles plus 1 ack cycle.
- `res_ack` sampled on cycle k means `res_valid` is low from cycle k+1. A new sample in cycle k+1 starts a new frame.
- `rst` mid-frame clears everything immediately (asynchronously); a partial frame is discarded.

## Structure
- Shared package `nn_pkg`: DATA_W, N_CLASS, IDX_W constants; the state enum {IDLE, COLLECT, HOLD}; the neuron word typedef (signed [DATA_W-1:0]).
- One natural sub-module, `max_cmp`: a combinational signed greater-than plus select, returning the new max and index. The FSM, counter and handshake stay in `acc_argmax`.

## Test plan
- Ascending sums 0,1,…,9 on consecutive cycles → `res_valid` the cycle after the 10th, `res_idx` = 9, `res_score` = 9.
- Negative mix: −5, −3, −200000, −3, −7, −9, −10, −11, −12, −13 → `res_idx` = 1 (tie keeps lowest), `res_score` = 0x3FFFFD.
- Sign boundary: 0x1FFFFF at index 4, 0x200000 at index 0, others 0 → `res_idx` = 4, `res_score` = 0x1FFFFF.
- Hold and ack:
  - Complete a frame, withhold `res_ack` 5 cycles, inject 2 `dout_valid` → outputs unchanged and `overrun` = 1.
  - Then `res_ack` → `res_valid` = 0 the next cycle, and `overrun` stays 1.
- Restart cases:
  - `start` after sample 6, then 10 samples 100..109 → `res_idx` = 9, `res_score` = 109, `overrun` = 0.
  - `start` coincident with a `dout_valid` → that sample is counted as index 0.
- Assert `rst` mid-frame at sample 3 → all outputs 0 within the same cycle; the following 10-sample frame produces a correct, independent result.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared constants and types for the neuron classification datapath.
package nn_pkg;

  // Default datapath dimensions; modules expose them as overridable parameters.
  localparam int NN_DATA_W  = 22;
  localparam int NN_N_CLASS = 10;
  localparam int NN_IDX_W   = 4;

  // Frame tracking states of the argmax back end.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // One completed neuron sum, two's-complement.
  typedef logic signed [NN_DATA_W-1:0] neuron_t;

endpackage

// File: rtl/max_cmp.sv
// Combinational running-max step: keeps the current max unless the new
// sample is strictly greater, so ties keep the earlier (lower) index.
module max_cmp
  import nn_pkg::*;
#(
  parameter int DATA_W = NN_DATA_W,
  parameter int IDX_W  = NN_IDX_W
) (
  input  logic signed [DATA_W-1:0] i_max,
  input  logic        [IDX_W-1:0]  i_max_idx,
  input  logic signed [DATA_W-1:0] i_sample,
  input  logic        [IDX_W-1:0]  i_sample_idx,
  output logic signed [DATA_W-1:0] o_max,
  output logic        [IDX_W-1:0]  o_idx
);

  logic w_gt;

  // Full-width signed compare, no truncation.
  assign w_gt  = (i_sample > i_max);
  assign o_max = w_gt ? i_sample : i_max;
  assign o_idx = w_gt ? i_sample_idx : i_max_idx;

endmodule

// File: rtl/acc_argmax.sv
// Argmax back end: tracks the signed maximum over a frame of N_CLASS neuron
// sums and presents the winning index/score through a valid/ack handshake.
module acc_argmax
  import nn_pkg::*;
#(
  parameter int DATA_W  = NN_DATA_W,
  parameter int N_CLASS = NN_N_CLASS,
  parameter int IDX_W   = NN_IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] dout,
  input  logic              dout_valid,
  input  logic              res_ack,
  output logic              res_valid,
  output logic [IDX_W-1:0]  res_idx,
  output logic [DATA_W-1:0] res_score,
  output logic              busy,
  output logic              overrun
);

  state_t                    r_state,     w_state_next;
  logic        [IDX_W-1:0]   r_count,     w_count_next;
  logic signed [DATA_W-1:0]  r_max,       w_max_next;
  logic        [IDX_W-1:0]   r_max_idx,   w_max_idx_next;
  logic                      r_res_valid, w_res_valid_next;
  logic        [IDX_W-1:0]   r_res_idx,   w_res_idx_next;
  logic        [DATA_W-1:0]  r_res_score, w_res_score_next;
  logic                      r_busy,      w_busy_next;
  logic                      r_overrun,   w_overrun_next;

  logic signed [DATA_W-1:0]  w_cmp_max;
  logic        [IDX_W-1:0]   w_cmp_idx;
  logic                      w_take0;
  logic                      w_last;

  max_cmp #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_max_cmp (
    .i_max        (r_max),
    .i_max_idx    (r_max_idx),
    .i_sample     ($signed(dout)),
    .i_sample_idx (r_count),
    .o_max        (w_cmp_max),
    .o_idx        (w_cmp_idx)
  );

  // State and datapath registers; rst clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_max       <= '0;
      r_max_idx   <= '0;
      r_res_valid <= 1'b0;
      r_res_idx   <= '0;
      r_res_score <= '0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_max       <= w_max_next;
      r_max_idx   <= w_max_idx_next;
      r_res_valid <= w_res_valid_next;
      r_res_idx   <= w_res_idx_next;
      r_res_score <= w_res_score_next;
      r_busy      <= w_busy_next;
      r_overrun   <= w_overrun_next;
    end
  end

  // Next-state and datapath update; start overrides everything, and a sample
  // arriving with start (or in IDLE) becomes sample 0 of a new frame.
  always_comb begin
    w_state_next     = r_state;
    w_count_next     = r_count;
    w_max_next       = r_max;
    w_max_idx_next   = r_max_idx;
    w_res_valid_next = r_res_valid;
    w_res_idx_next   = r_res_idx;
    w_res_score_next = r_res_score;
    w_overrun_next   = r_overrun;
    w_take0          = dout_valid && (start || (r_state == IDLE));
    w_last           = (r_count == IDX_W'(N_CLASS - 1));

    if (start) begin
      w_state_next     = IDLE;
      w_count_next     = '0;
      w_res_valid_next = 1'b0;
      w_overrun_next   = 1'b0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (dout_valid) begin
            w_max_next     = w_cmp_max;
            w_max_idx_next = w_cmp_idx;
            w_count_next   = r_count + IDX_W'(1);
            if (w_last) begin
              // Final sample: publish the max including this sample.
              w_state_next     = HOLD;
              w_count_next     = '0;
              w_res_valid_next = 1'b1;
              w_res_idx_next   = w_cmp_idx;
              w_res_score_next = w_cmp_max;
            end
          end
        end
        HOLD: begin
          if (dout_valid) begin
            w_overrun_next = 1'b1;
          end
          if (res_ack) begin
            w_state_next     = IDLE;
            w_res_valid_next = 1'b0;
            w_count_next     = '0;
          end
        end
        default: ;
      endcase
    end

    if (w_take0) begin
      w_max_next     = $signed(dout);
      w_max_idx_next = '0;
      if (N_CLASS == 1) begin
        // Single-neuron frames complete on their only sample.
        w_state_next     = HOLD;
        w_count_next     = '0;
        w_res_valid_next = 1'b1;
        w_res_idx_next   = '0;
        w_res_score_next = dout;
      end else begin
        w_state_next = COLLECT;
        w_count_next = IDX_W'(1);
      end
    end

    w_busy_next = (w_state_next == COLLECT);
  end

  assign res_valid = r_res_valid;
  assign res_idx   = r_res_idx;
  assign res_score = r_res_score;
  assign busy      = r_busy;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_acc_argmax.sv
// Directed self-checking bench for acc_argmax: table-driven frames plus
// hand-written hold/ack, restart and mid-frame reset sequences.
module tb_acc_argmax;

  logic        clk;
  logic        rst;
  logic        start;
  logic [21:0] dout;
  logic        dout_valid;
  logic        res_ack;
  logic        res_valid;
  logic [3:0]  res_idx;
  logic [21:0] res_score;
  logic        busy;
  logic        overrun;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [9:0][21:0] s;
    logic [3:0]       idx;
    logic [21:0]      score;
  } vec_t;

  vec_t vecs[6];

  acc_argmax dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dout       (dout),
    .dout_valid (dout_valid),
    .res_ack    (res_ack),
    .res_valid  (res_valid),
    .res_idx    (res_idx),
    .res_score  (res_score),
    .busy       (busy),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", nm, act);
    end
  endtask

  task automatic send(input logic [21:0] v);
    dout       = v;
    dout_valid = 1'b1;
    tick();
    dout_valid = 1'b0;
  endtask

  task automatic ack();
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    start      = 1'b0;
    dout       = '0;
    dout_valid = 1'b0;
    res_ack    = 1'b0;

    // Vector table: ten samples, expected index and score.
    for (int i = 0; i < 10; i++) begin
      vecs[0].s[i] = 22'(i);
      vecs[3].s[i] = 22'd7;
      vecs[4].s[i] = 22'(9 - i);
      vecs[5].s[i] = 22'(-1);
      vecs[2].s[i] = 22'd0;
    end
    vecs[0].idx = 4'd9; vecs[0].score = 22'd9;
    vecs[1].s[0] = 22'(-5);      vecs[1].s[1] = 22'(-3);
    vecs[1].s[2] = 22'(-200000); vecs[1].s[3] = 22'(-3);
    vecs[1].s[4] = 22'(-7);      vecs[1].s[5] = 22'(-9);
    vecs[1].s[6] = 22'(-10);     vecs[1].s[7] = 22'(-11);
    vecs[1].s[8] = 22'(-12);     vecs[1].s[9] = 22'(-13);
    vecs[1].idx = 4'd1; vecs[1].score = 22'h3FFFFD;
    vecs[2].s[0] = 22'h200000; vecs[2].s[4] = 22'h1FFFFF;
    vecs[2].idx = 4'd4; vecs[2].score = 22'h1FFFFF;
    vecs[3].idx = 4'd0; vecs[3].score = 22'd7;
    vecs[4].idx = 4'd0; vecs[4].score = 22'd9;
    vecs[5].s[9] = 22'd5;
    vecs[5].idx = 4'd9; vecs[5].score = 22'd5;

    // Reset state.
    #3;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_idx",   32'(res_idx),   32'd0);
    chk("rst_res_score", 32'(res_score), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_overrun",   32'(overrun),   32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Table-driven frames.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 10; i++) begin
        send(vecs[v].s[i]);
        if (i == 0) chk($sformatf("v%0d_busy_first", v), 32'(busy), 32'd1);
        if (i == 8) chk($sformatf("v%0d_valid_early", v), 32'(res_valid), 32'd0);
      end
      chk($sformatf("v%0d_res_valid", v), 32'(res_valid), 32'd1);
      chk($sformatf("v%0d_res_idx", v),   32'(res_idx),   32'(vecs[v].idx));
      chk($sformatf("v%0d_res_score", v), 32'(res_score), 32'(vecs[v].score));
      chk($sformatf("v%0d_busy_hold", v), 32'(busy),      32'd0);
      chk($sformatf("v%0d_overrun", v),   32'(overrun),   32'd0);
      ack();
      chk($sformatf("v%0d_valid_after_ack", v), 32'(res_valid), 32'd0);
    end

    // Hold with late ack and dropped samples.
    for (int i = 0; i < 10; i++) send(vecs[0].s[i]);
    tick();
    send(22'd1000);
    tick();
    send(22'd2000);
    tick();
    chk("hold_res_valid", 32'(res_valid), 32'd1);
    chk("hold_res_idx",   32'(res_idx),   32'd9);
    chk("hold_res_score", 32'(res_score), 32'd9);
    chk("hold_overrun",   32'(overrun),   32'd1);
    ack();
    chk("hold_valid_after_ack",   32'(res_valid), 32'd0);
    chk("hold_overrun_after_ack", 32'(overrun),   32'd1);

    // New frame right after ack, aborted by start after sample 6.
    for (int i = 0; i < 7; i++) begin
      send(22'(1000 + i));
      if (i == 0) chk("post_ack_busy", 32'(busy), 32'd1);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy",    32'(busy),    32'd0);
    chk("start_overrun", 32'(overrun), 32'd0);
    for (int i = 0; i < 10; i++) send(22'(100 + i));
    chk("restart_valid",   32'(res_valid), 32'd1);
    chk("restart_idx",     32'(res_idx),   32'd9);
    chk("restart_score",   32'(res_score), 32'd109);
    chk("restart_overrun", 32'(overrun),   32'd0);
    ack();

    // start coincident with a sample: that sample is index 0.
    send(22'd50);
    send(22'd60);
    send(22'd70);
    start      = 1'b1;
    dout       = 22'(-1);
    dout_valid = 1'b1;
    tick();
    start      = 1'b0;
    dout_valid = 1'b0;
    chk("co_start_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 9; i++) begin
      send(22'(-2));
      if (i == 7) chk("co_start_valid_early", 32'(res_valid), 32'd0);
    end
    chk("co_start_valid", 32'(res_valid), 32'd1);
    chk("co_start_idx",   32'(res_idx),   32'd0);
    chk("co_start_score", 32'(res_score), 32'h3FFFFF);
    ack();

    // Asynchronous reset at sample 3 of a frame.
    send(22'd5000);
    send(22'd5000);
    send(22'd5000);
    dout       = 22'd5000;
    dout_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy",      32'(busy),      32'd0);
    chk("arst_res_valid", 32'(res_valid), 32'd0);
    chk("arst_res_idx",   32'(res_idx),   32'd0);
    chk("arst_res_score", 32'(res_score), 32'd0);
    chk("arst_overrun",   32'(overrun),   32'd0);
    dout_valid = 1'b0;
    #2;
    rst = 1'b0;
    tick();
    send(22'd10); send(22'd20); send(22'd5);  send(22'd30); send(22'd30);
    send(22'(-1)); send(22'd0); send(22'd29); send(22'd2);  send(22'd1);
    chk("post_rst_valid", 32'(res_valid), 32'd1);
    chk("post_rst_idx",   32'(res_idx),   32'd3);
    chk("post_rst_score", 32'(res_score), 32'd30);
    ack();
    chk("post_rst_valid_after_ack", 32'(res_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
